acc_argmax: RTL and testbench
=============================

ACC_ARGMAX -- requirements
Module: acc_argmax

Interface
REQ-001 Parameter NCLASS, default 10: scores per image (one per output neuron); legal range 2..16.
REQ-002 Parameter DW, default 22: score width, equal to the accumulator output width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 din  input  DW  two's-complement neuron score from the upstream accumulator.
REQ-006 din_valid  input  1  din is valid this cycle; one score is consumed per asserted cycle.
REQ-007 class_out  output  4  index (0..NCLASS-1) of the winning score for the last completed image.
REQ-008 max_out  output  DW  winning score value for the last completed image.
REQ-009 done  output  1  one-cycle pulse: class_out and max_out have just been updated.
REQ-010 busy  output  1  high while an image is partially received (state SCAN).
REQ-011 img_cnt  output  8  number of completed images since reset; wraps 255 -> 0.

Function
REQ-012 The block SHALL implement two states: IDLE (no score held) and SCAN (1..NCLASS-1 scores of the current image consumed).
REQ-013 IDLE + din_valid SHALL load din into the running max, load 0 into the running index, set the score counter to 1 and go to SCAN.
REQ-014 SCAN + din_valid SHALL signed-compare din against the running max and replace max and index only when din is strictly greater.
REQ-015 Ties SHALL keep the earlier (lower) index.
REQ-016 The score counter SHALL increment on each consumed score; din_valid low SHALL hold all state (gaps are allowed).
REQ-017 On consumption of score number NCLASS, the block SHALL, on that same edge, register the final winner (including that score) into class_out and max_out, assert done for exactly the following cycle, increment img_cnt, and return to IDLE.
REQ-018 Latency SHALL be 1 cycle: done and the new outputs are visible in the cycle after the edge that samples the last valid score.
REQ-019 class_out and max_out SHALL hold their values until the next image completes, independent of din and din_valid.
REQ-020 Back-to-back operation SHALL be supported: a din_valid in the cycle where done is high is the first score of the next image, with no lost cycle.
REQ-021 Comparison SHALL be full-width signed; the most negative value (-2^(DW-1)) SHALL be a legal score.
REQ-022 busy SHALL be high exactly while in SCAN; busy SHALL be 0 in the done cycle unless a new score was also consumed on that edge.
REQ-023 img_cnt SHALL wrap modulo 256 with no flag.

Reset
REQ-024 rst high SHALL force state to IDLE; the score counter, running max, running index, class_out, max_out and img_cnt to 0; and done and busy to 0.
REQ-025 rst SHALL take priority over din_valid on the same edge; the score is dropped.
REQ-026 rst asserted mid-image SHALL discard the partial image, with no done pulse and no img_cnt change.
REQ-027 The first din_valid after rst deasserts SHALL be treated as index 0 of a new image.

Verification
REQ-028 Scores 5,-3,100,7,2,9,0,1,-50,99 on 10 consecutive cycles -> one done pulse; class_out=2, max_out=100, img_cnt=1.
REQ-029 All ten scores = -2097152 (0x200000) -> class_out=0, max_out=0x200000; tie rule and signed minimum both checked.
REQ-030 Two images back to back with no idle cycle, winners at index 9 then index 0 -> done pulses exactly 10 cycles apart; class_out 9 then 0; img_cnt 1 then 2.
REQ-031 Ten scores with din_valid low on alternate cycles, maximum at index 4 -> class_out=4; no done pulse before the 10th valid score.
REQ-032 rst pulsed after 6 scores, then a fresh 10-score image with its maximum at index 3 -> no done pulse for the aborted image; class_out=3; img_cnt=1.
REQ-033 256 complete images -> img_cnt reads 0 after the 256th done pulse.

Source files
------------

// File: rtl/acc_argmax.sv
// Streaming argmax over NCLASS signed scores per image; registers the winning
// index/value one cycle after the last score and pulses done.
module acc_argmax #(
  parameter int NCLASS = 10,
  parameter int DW     = 22
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  output logic [3:0]    class_out,
  output logic [DW-1:0] max_out,
  output logic          done,
  output logic          busy,
  output logic [7:0]    img_cnt
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [3:0] LAST = 4'(NCLASS - 1);

  state_t        state, state_n;
  logic [3:0]    cnt, cnt_n;
  logic [DW-1:0] run_max, run_max_n;
  logic [3:0]    run_idx, run_idx_n;
  logic [3:0]    class_n;
  logic [DW-1:0] max_n;
  logic          done_n;
  logic [7:0]    img_cnt_n;

  logic          greater;
  logic [DW-1:0] win_max;
  logic [3:0]    win_idx;

  // Strictly greater keeps the earlier index on ties.
  assign greater = $signed(din) > $signed(run_max);
  assign win_max = greater ? din : run_max;
  assign win_idx = greater ? cnt : run_idx;

  assign busy = (state == SCAN);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    run_max_n = run_max;
    run_idx_n = run_idx;
    class_n   = class_out;
    max_n     = max_out;
    done_n    = 1'b0;
    img_cnt_n = img_cnt;
    unique case (state)
      IDLE: begin
        if (din_valid) begin
          run_max_n = din;
          run_idx_n = '0;
          cnt_n     = 4'd1;
          state_n   = SCAN;
        end
      end
      SCAN: begin
        if (din_valid) begin
          if (cnt == LAST) begin
            class_n   = win_idx;
            max_n     = win_max;
            done_n    = 1'b1;
            img_cnt_n = img_cnt + 8'd1;
            cnt_n     = '0;
            state_n   = IDLE;
          end else begin
            run_max_n = win_max;
            run_idx_n = win_idx;
            cnt_n     = cnt + 4'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      run_max   <= '0;
      run_idx   <= '0;
      class_out <= '0;
      max_out   <= '0;
      done      <= 1'b0;
      img_cnt   <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      run_max   <= run_max_n;
      run_idx   <= run_idx_n;
      class_out <= class_n;
      max_out   <= max_n;
      done      <= done_n;
      img_cnt   <= img_cnt_n;
    end
  end

endmodule

// File: tb/tb_acc_argmax.sv
// Directed and randomized bench for acc_argmax against an array-based argmax model.
module tb_acc_argmax;
  localparam int NCLASS = 10;
  localparam int DW     = 22;
  localparam int SMIN   = -(1 << (DW - 1));
  localparam int SMAX   = (1 << (DW - 1)) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] din = '0;
  logic          din_valid = 1'b0;
  logic [3:0]    class_out;
  logic [DW-1:0] max_out;
  logic          done;
  logic          busy;
  logic [7:0]    img_cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_done_cyc = 0;

  int            exp_class = 0;
  logic [DW-1:0] exp_max = '0;
  int            exp_img = 0;

  acc_argmax #(.NCLASS(NCLASS), .DW(DW)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .class_out(class_out), .max_out(max_out), .done(done),
    .busy(busy), .img_cnt(img_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: drive inputs, wait for the edge, settle past it.
  task automatic step(input bit v, input int d);
    din_valid = v;
    din = DW'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic check_held(input string tag);
    chk({tag, "_class"}, 32'(class_out), 32'(exp_class));
    chk({tag, "_max"}, 32'(max_out), 32'(exp_max));
    chk({tag, "_img"}, 32'(img_cnt), 32'(exp_img));
  endtask

  function automatic int rnd_score();
    case ($urandom_range(0, 4))
      0: return int'($urandom_range(0, 8)) - 4;
      1: return SMIN;
      2: return SMAX;
      default: return int'($urandom_range(0, (1 << DW) - 1)) + SMIN;
    endcase
  endfunction

  // gap: 0 none, 1 idle cycle between every score, 2 random idle cycles.
  task automatic send_image(input int s[NCLASS], input int gap);
    int idx, mx;
    idx = 0;
    mx = s[0];
    for (int i = 1; i < NCLASS; i++)
      if (s[i] > mx) begin
        mx = s[i];
        idx = i;
      end
    for (int i = 0; i < NCLASS; i++) begin
      if ((gap == 1 && i > 0) || (gap == 2 && $urandom_range(0, 3) == 0)) begin
        step(1'b0, int'($urandom));
        chk("gap_done", 32'(done), 32'd0);
        check_held("gap_hold");
      end
      step(1'b1, s[i]);
      if (i < NCLASS - 1) begin
        chk("mid_done", 32'(done), 32'd0);
        chk("mid_busy", 32'(busy), 32'd1);
      end
    end
    exp_class = idx;
    exp_max = DW'(mx);
    exp_img = (exp_img + 1) % 256;
    chk("fin_done", 32'(done), 32'd1);
    chk("fin_busy", 32'(busy), 32'd0);
    check_held("fin");
    last_done_cyc = cyc;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b1, 12345);
    rst = 1'b0;
    exp_class = 0;
    exp_max = '0;
    exp_img = 0;
  endtask

  initial begin
    int img[NCLASS];
    int c1;

    rst = 1'b1;
    step(1'b0, 0);
    step(1'b0, 0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    check_held("rst");
    rst = 1'b0;

    img = '{5, -3, 100, 7, 2, 9, 0, 1, -50, 99};
    send_image(img, 0);
    chk("r28_class", 32'(class_out), 32'd2);
    chk("r28_max", 32'(max_out), 32'd100);
    chk("r28_img", 32'(img_cnt), 32'd1);
    step(1'b0, 0);
    chk("done_one_cycle", 32'(done), 32'd0);
    check_held("idle_hold");

    img = '{default: SMIN};
    send_image(img, 0);
    chk("r29_class", 32'(class_out), 32'd0);
    chk("r29_max", 32'(max_out), 32'h200000);

    img = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 50};
    send_image(img, 0);
    chk("r30a_class", 32'(class_out), 32'd9);
    c1 = last_done_cyc;
    img = '{60, 2, 3, 4, 5, 6, 7, 8, 9, 60};
    send_image(img, 0);
    chk("r30b_class", 32'(class_out), 32'd0);
    chk("r30_spacing", 32'(last_done_cyc - c1), 32'd10);

    img = '{-9, -8, -7, -6, 1000, -4, 999, 1000, -1, 0};
    send_image(img, 1);
    chk("r31_class", 32'(class_out), 32'd4);

    for (int i = 0; i < 6; i++) step(1'b1, 3000 + i);
    do_reset();
    chk("r32_rst_done", 32'(done), 32'd0);
    chk("r32_rst_busy", 32'(busy), 32'd0);
    check_held("r32_rst");
    img = '{1, 2, 3, 777, 5, -6, 7, 8, 9, 10};
    send_image(img, 0);
    chk("r32_class", 32'(class_out), 32'd3);
    chk("r32_img", 32'(img_cnt), 32'd1);

    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < NCLASS; i++) img[i] = rnd_score();
      send_image(img, 2);
    end

    do_reset();
    for (int n = 0; n < 256; n++) begin
      for (int i = 0; i < NCLASS; i++) img[i] = rnd_score();
      send_image(img, 2);
    end
    chk("r33_wrap", 32'(img_cnt), 32'd0);

    step(1'b0, 0);
    chk("end_done", 32'(done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
